// File: rtl/stack_controller_if.sv
// Opcode handshake plus shift-register control/readback bundle for stack_controller.
// The slave side is the controller; the master side is the decoder plus shift register.
interface stack_controller_if #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned DEPTH_W = 4
) ();
  logic               op_valid;
  logic [2:0]         op_code;
  logic               op_data;
  logic               op_ready;
  logic [SIZE-1:0]    stack_q;
  logic [2:0]         sr_mode;
  logic               sr_d;
  logic [DEPTH_W-1:0] depth;
  logic               err_overflow;
  logic               err_underflow;

  modport master (
    output op_valid, op_code, op_data, stack_q,
    input  op_ready, sr_mode, sr_d, depth, err_overflow, err_underflow
  );

  modport slave (
    input  op_valid, op_code, op_data, stack_q,
    output op_ready, sr_mode, sr_d, depth, err_overflow, err_underflow
  );
endinterface

// File: rtl/stack_controller.sv
// Expands calculator opcodes into one or two shift-register mode cycles, tracks stack depth
// and rejects overflow/underflow. All outputs are registered.
module stack_controller #(
  parameter int unsigned SIZE    = 8,
  parameter int unsigned DEPTH_W = 4
) (
  input logic               clk,
  input logic               reset,
  stack_controller_if.slave bus
);

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpPush  = 3'b001;
  localparam logic [2:0] OpDrop  = 3'b010;
  localparam logic [2:0] OpSwap  = 3'b011;
  localparam logic [2:0] OpDup   = 3'b100;
  localparam logic [2:0] OpAnd   = 3'b101;
  localparam logic [2:0] OpXor   = 3'b110;
  localparam logic [2:0] OpClear = 3'b111;

  localparam logic [2:0] ModeIdle  = 3'b000;
  localparam logic [2:0] ModePush  = 3'b001;
  localparam logic [2:0] ModePop   = 3'b010;
  localparam logic [2:0] ModeSwap  = 3'b011;
  localparam logic [2:0] ModeReset = 3'b111;

  localparam logic [DEPTH_W-1:0] DepthFull = DEPTH_W'(SIZE);
  localparam logic [DEPTH_W-1:0] DepthOne  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DepthTwo  = DEPTH_W'(2);

  typedef enum logic [1:0] {StIdle, StIssue, StIssue2} state_e;

  state_e             r_state, w_state;
  logic               r_op_ready, w_op_ready;
  logic [2:0]         r_sr_mode, w_sr_mode;
  logic               r_sr_d, w_sr_d;
  logic [DEPTH_W-1:0] r_depth, w_depth;
  logic               r_ovf, w_ovf;
  logic               r_unf, w_unf;
  logic               r_two, w_two;
  logic               r_is_and, w_is_and;
  logic               r_a, w_a;
  logic               r_b, w_b;

  // Only the top two bits are consumed; the rest of the readback is intentionally ignored.
  logic w_unused_stack;
  assign w_unused_stack = ^bus.stack_q;

  always_comb begin
    w_state  = r_state;
    w_sr_mode = ModeIdle;
    w_sr_d   = 1'b0;
    w_depth  = r_depth;
    w_ovf    = 1'b0;
    w_unf    = 1'b0;
    w_two    = r_two;
    w_is_and = r_is_and;
    w_a      = r_a;
    w_b      = r_b;

    case (r_state)
      StIdle: begin
        if (bus.op_valid && r_op_ready) begin
          w_state  = StIssue;
          w_a      = bus.stack_q[0];
          w_b      = bus.stack_q[1];
          w_two    = 1'b0;
          w_is_and = (bus.op_code == OpAnd);
          unique case (bus.op_code)
            OpNop: ;
            OpPush, OpDup: begin
              if (r_depth < DepthFull) begin
                w_sr_mode = ModePush;
                w_sr_d    = (bus.op_code == OpPush) ? bus.op_data : bus.stack_q[0];
                w_depth   = r_depth + DepthOne;
              end else begin
                w_ovf = 1'b1;
              end
            end
            OpDrop: begin
              if (r_depth >= DepthOne) begin
                w_sr_mode = ModePop;
                w_depth   = r_depth - DepthOne;
              end else begin
                w_unf = 1'b1;
              end
            end
            OpSwap: begin
              if (r_depth >= DepthTwo) begin
                w_sr_mode = ModeSwap;
              end else begin
                w_unf = 1'b1;
              end
            end
            OpAnd, OpXor: begin
              if (r_depth >= DepthTwo) begin
                w_sr_mode = ModePop;
                w_depth   = r_depth - DepthOne;
                w_two     = 1'b1;
              end else begin
                w_unf = 1'b1;
              end
            end
            OpClear: begin
              w_sr_mode = ModeReset;
              w_depth   = '0;
            end
          endcase
        end
      end
      StIssue: begin
        if (r_two) begin
          // Second half of a binary op: push the result computed from the latched operands.
          w_state   = StIssue2;
          w_sr_mode = ModePush;
          w_sr_d    = r_is_and ? (r_a & r_b) : (r_a ^ r_b);
        end else begin
          w_state = StIdle;
        end
      end
      StIssue2: w_state = StIdle;
      default:  w_state = StIdle;
    endcase

    w_op_ready = (w_state == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_op_ready <= 1'b0;
      r_sr_mode  <= ModeReset;
      r_sr_d     <= 1'b0;
      r_depth    <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_two      <= 1'b0;
      r_is_and   <= 1'b0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_op_ready <= w_op_ready;
      r_sr_mode  <= w_sr_mode;
      r_sr_d     <= w_sr_d;
      r_depth    <= w_depth;
      r_ovf      <= w_ovf;
      r_unf      <= w_unf;
      r_two      <= w_two;
      r_is_and   <= w_is_and;
      r_a        <= w_a;
      r_b        <= w_b;
    end
  end

  assign bus.op_ready      = r_op_ready;
  assign bus.sr_mode       = r_sr_mode;
  assign bus.sr_d          = r_sr_d;
  assign bus.depth         = r_depth;
  assign bus.err_overflow  = r_ovf;
  assign bus.err_underflow = r_unf;

endmodule
